apb_slave_regbank: RTL and testbench

//  APB completer that sits directly downstream of the ICB-to-APB bridge. It terminates the apb_bus master-side

---
 rtl/apb_slave_regbank.sv | 129 ++++++++++++
 tb/tb_apb_slave_regbank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB completer: DEPTH x 32-bit register bank with fixed wait states
// and saturating read/write transfer counters.
module apb_slave_regbank #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] OOR_RDATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        pready_nxt;
  logic        latch, load_rd, complete;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] bank [DEPTH];
  logic [31:0] look_addr;
  logic        hit;
  logic [AW-1:0] idx;

  // With zero wait states read data is loaded on the setup edge, before addr_q holds the address.
  assign look_addr = (state == S_IDLE) ? paddr : addr_q;
  assign hit = ({1'b0, look_addr} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, look_addr} <  ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
  assign idx = look_addr[2 +: AW];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pready_nxt = pready;
    latch      = 1'b0;
    load_rd    = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (psel && !penable) begin
          latch   = 1'b1;
          cnt_nxt = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_nxt  = S_READY;
            pready_nxt = 1'b1;
            load_rd    = !pwrite;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_nxt  = S_IDLE;
          pready_nxt = 1'b0;
        end else if (penable) begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt  = S_READY;
            pready_nxt = 1'b1;
            load_rd    = !write_q;
          end
        end
      end
      S_READY: begin
        if (!psel) begin
          state_nxt  = S_IDLE;
          pready_nxt = 1'b0;
        end else if (penable && pready) begin
          complete   = 1'b1;
          state_nxt  = S_IDLE;
          pready_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        pready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      pready   <= 1'b0;
      prdata   <= 32'h0;
      wr_count <= 16'h0;
      rd_count <= 16'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      write_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= 32'h0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pready <= pready_nxt;
      if (latch) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        write_q <= pwrite;
      end
      if (load_rd) prdata <= hit ? bank[idx] : OOR_RDATA;
      if (complete) begin
        if (write_q) begin
          if (hit) begin
            bank[idx] <= wdata_q;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end
        end else if (rd_count != 16'hFFFF) begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - checks two regbank instances (2 and 0 wait states) against a
// behavioural bank/counter model.
module tb_apb_slave_regbank;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic [15:0] wr_count [2];
  logic [15:0] rd_count [2];

  int          waits_exp [2] = '{2, 0};
  logic [31:0] mbank [2][DEPTH];
  int          mwr [2];
  int          mrd [2];
  logic [31:0] mrdata [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .wr_count(wr_count[0]), .rd_count(rd_count[0]));

  apb_slave_regbank #(.WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .wr_count(wr_count[1]), .rd_count(rd_count[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < DEPTH; i++) mbank[w][i] = 32'h0;
      mwr[w] = 0;
      mrd[w] = 0;
      mrdata[w] = 32'h0;
    end
  endtask

  task automatic idle_bus(input int w);
    psel[w] = 1'b0; penable[w] = 1'b0; pwrite[w] = 1'b0;
    paddr[w] = 32'h0; pwdata[w] = 32'h0;
  endtask

  task automatic check_state(input string tag, input int w);
    chk($sformatf("%s_wr%0d", tag, w), 32'(wr_count[w]), 32'(mwr[w]));
    chk($sformatf("%s_rd%0d", tag, w), 32'(rd_count[w]), 32'(mrd[w]));
    chk($sformatf("%s_prdata%0d", tag, w), prdata[w], mrdata[w]);
  endtask

  // Called at a falling edge; returns one falling edge after the completing rising edge.
  task automatic xfer(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int waits = 0;
    psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = d;
    @(negedge clk);
    penable[w] = 1'b1;
    while (pready[w] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk($sformatf("waits%0d_%h", w, a), 32'(waits), 32'(waits_exp[w]));
    if (!wr && waits < 40) begin
      mrdata[w] = in_range(a) ? mbank[w][widx(a)] : 32'h0;
      chk($sformatf("rdata%0d_%h", w, a), prdata[w], mrdata[w]);
    end
    @(negedge clk);
    if (waits < 40) begin
      if (wr && in_range(a)) begin
        mbank[w][widx(a)] = d;
        mwr[w] = sat_inc(mwr[w]);
      end else if (!wr) begin
        mrd[w] = sat_inc(mrd[w]);
      end
    end
    check_state("post", w);
    idle_bus(w);
  endtask

  initial begin
    idle_bus(0);
    idle_bus(1);
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("rst_pready%0d", w), 32'(pready[w]), 32'h0);
      check_state("rst", w);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single write/readback with two wait states.
    xfer(0, 1'b1, 32'h1000_0004, 32'hA5A5_0001);
    xfer(0, 1'b0, 32'h1000_0004, 32'h0);
    chk("t1_prdata", prdata[0], 32'hA5A5_0001);
    chk("t1_wr", 32'(wr_count[0]), 32'd1);
    chk("t1_rd", 32'(rd_count[0]), 32'd1);

    // Zero wait states, back-to-back over the whole bank.
    for (int i = 0; i < DEPTH; i++) xfer(1, 1'b1, BASE + 32'(4 * i) + 32'($urandom_range(0, 3)), $urandom);
    for (int i = 0; i < DEPTH; i++) xfer(1, 1'b0, BASE + 32'(4 * i), 32'h0);

    // Out-of-range write then read.
    xfer(0, 1'b1, 32'h1000_0040, 32'h0000_1234);
    xfer(0, 1'b0, 32'h1000_0040, 32'h0);
    chk("t3_oor", prdata[0], 32'h0);

    // Access phase without setup is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h1000_0008;
    @(negedge clk);
    chk("noset_pready", 32'(pready[0]), 32'h0);
    idle_bus(0);
    @(negedge clk);
    check_state("noset", 0);

    // Abort in the second wait cycle.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h1000_0008; pwdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    idle_bus(0);
    @(negedge clk);
    chk("abort_pready", 32'(pready[0]), 32'h0);
    check_state("abort", 0);
    xfer(0, 1'b0, 32'h1000_0008, 32'h0);
    chk("abort_word2", prdata[0], 32'h0);

    // Random traffic across both instances, including around the window edges.
    for (int n = 0; n < 40; n++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           BASE - 32'd16 + 32'($urandom_range(0, 95)), $urandom);
    end

    // Reset during a wait cycle.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h1000_000C; pwdata[0] = 32'h5555_AAAA;
    @(negedge clk);
    penable[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bus(0);
    model_reset();
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("mrst_pready%0d", w), 32'(pready[w]), 32'h0);
      check_state("mrst", w);
    end
    xfer(0, 1'b0, 32'h1000_0004, 32'h0);
    xfer(0, 1'b0, 32'h1000_000C, 32'h0);
    xfer(0, 1'b1, 32'h1000_0030, 32'h0BAD_F00D);
    xfer(0, 1'b0, 32'h1000_0030, 32'h0);

    // Write counter saturation.
    force dut1.wr_count = 16'hFFFE;
    #1;
    release dut1.wr_count;
    mwr[1] = 65534;
    @(negedge clk);
    chk("sat_preload", 32'(wr_count[1]), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) xfer(1, 1'b1, BASE + 32'(4 * i), $urandom);
    chk("sat_final", 32'(wr_count[1]), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
